// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES controller reader: FSM states,
// button bit positions in the controller words, and default timing.
package nes_pad_pkg;

  localparam int DEF_HALF_CYCLES = 64;
  localparam int DEF_POLL_CYCLES = 357954;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

endpackage

// File: rtl/nes_pad_reader_sync2.sv
// Two-flop synchronizer for an asynchronous pad data line. Resets to 1,
// which is the released (not pressed) level of the pad serial output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_reader.sv
// Reads two NES controllers through their 4021 shift registers: latch pulse,
// then eight serial bits per pad, published atomically with a valid pulse.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int HALF_CYCLES = DEF_HALF_CYCLES,
  parameter int POLL_CYCLES = DEF_POLL_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       poll,
  input  logic       pad1_data,
  input  logic       pad2_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] controller1,
  output logic [7:0] controller2,
  output logic       valid,
  output logic       busy
);

  localparam int IW = $clog2(POLL_CYCLES);
  localparam int PW = $clog2(2 * HALF_CYCLES);
  localparam logic [IW-1:0] POLL_LAST = IW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF_CYCLES - 1);
  localparam logic [PW-1:0] FULL_LAST = PW'(2 * HALF_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(BTN_RIGHT);

  state_t          r_state;
  state_t          w_next;
  logic            w_sample;
  logic [IW-1:0]   r_ivl;
  logic [PW-1:0]   r_phase;
  logic [2:0]      r_bit;
  logic [7:0]      r_sr1;
  logic [7:0]      r_sr2;
  logic [7:0]      w_sr1_next;
  logic [7:0]      w_sr2_next;
  logic            w_d1;
  logic            w_d2;
  logic            r_pad_latch;
  logic            r_pad_clk;
  logic            r_valid;
  logic            r_busy;
  logic [7:0]      r_ctrl1;
  logic [7:0]      r_ctrl2;

  sync2 u_sync_pad1 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pad1_data),
    .o_q   (w_d1)
  );

  sync2 u_sync_pad2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pad2_data),
    .o_q   (w_d2)
  );

  // Pads drive low for pressed; shift right so the first bit (A) ends in bit0.
  assign w_sr1_next = {~w_d1, r_sr1[7:1]};
  assign w_sr2_next = {~w_d2, r_sr2[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    case (r_state)
      IDLE:   if (poll || (enable && r_ivl == POLL_LAST)) w_next = LATCH;
      LATCH:  if (r_phase == FULL_LAST) w_next = GAP;
      GAP: begin
        if (r_phase == HALF_LAST) begin
          w_sample = 1'b1;
          w_next   = CLK_HI;
        end
      end
      CLK_HI: if (r_phase == HALF_LAST) w_next = CLK_LO;
      CLK_LO: begin
        if (r_phase == HALF_LAST) begin
          w_sample = 1'b1;
          w_next   = (r_bit == LAST_BIT) ? DONE : CLK_HI;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Counters: interval only runs in IDLE, phase restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ivl   <= '0;
      r_phase <= '0;
      r_bit   <= '0;
    end else begin
      if (r_state != IDLE || w_next != IDLE) r_ivl <= '0;
      else if (enable)                       r_ivl <= r_ivl + 1'b1;

      if (r_state == IDLE || w_next != r_state) r_phase <= '0;
      else                                      r_phase <= r_phase + 1'b1;

      if (r_state == IDLE) r_bit <= '0;
      else if (w_sample)   r_bit <= r_bit + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_sr1 <= w_sr1_next;
      r_sr2 <= w_sr2_next;
    end
  end

  // Outputs are decoded from the next state so they change in step with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_ctrl1     <= 8'h00;
      r_ctrl2     <= 8'h00;
    end else begin
      r_pad_latch <= (w_next == LATCH);
      r_pad_clk   <= (w_next == CLK_HI);
      r_valid     <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      if (w_next == DONE) begin
        r_ctrl1 <= w_sr1_next;
        r_ctrl2 <= w_sr2_next;
      end
    end
  end

  assign pad_latch   = r_pad_latch;
  assign pad_clk     = r_pad_clk;
  assign valid       = r_valid;
  assign busy        = r_busy;
  assign controller1 = r_ctrl1;
  assign controller2 = r_ctrl2;

endmodule
